// File: rtl/uart_rx_core.sv
// uart_rx_core
// -----------------------------------------------------------------------------
// 16x-oversampling UART receiver. It consumes the 16x baud enable from the
// clock generator and deserialises RX, LSB first, into a byte. It supports 7 or
// 8 data bits, optional even/odd parity and one stop bit. Each finished frame
// goes into a one-deep holding register that the APB wrapper reads.
//
// Parameters
//   SYNC_STAGES  number of CLK flops that synchronise RX (2..3)
//   FILTER_EN    1: 3-sample majority filter on ticks, 0: plain tick sample
//
// Ports
//   CLK           system clock, all logic on the rising edge
//   RESET         synchronous active-high reset
//   baud_clock    one-CLK-wide 16x baud enable ("tick")
//   RX            asynchronous serial input, idle high
//   bit8          1 = 8 data bits, 0 = 7 data bits
//   parity_en     1 = a parity bit follows the data bits
//   odd_n_even    1 = odd parity, 0 = even parity
//   read_rx_byte  one-CLK pulse: host consumed rx_byte
//   rx_byte       held data (bit7 = 0 in 7-bit mode)
//   receive_full  rx_byte holds unread data
//   parity_err    parity error on the held byte
//   overflow      a frame completed while receive_full was set
//   framing_err   one-CLK pulse when the stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter bit FILTER_EN   = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       baud_clock,
    input  logic       RX,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       receive_full,
    output logic       parity_err,
    output logic       overflow,
    output logic       framing_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // RX synchroniser and tick-rate filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;
    logic [2:0]             samp_q;
    logic                   rx_filt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // The sample history moves only on ticks, so the filter rejects glitches
    // shorter than about one tick period.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            samp_q <= 3'b111;
        end else if (baud_clock) begin
            samp_q <= {samp_q[1:0], rx_sync};
        end
    end

    assign rx_filt = FILTER_EN ? ((samp_q[0] & samp_q[1]) |
                                  (samp_q[0] & samp_q[2]) |
                                  (samp_q[1] & samp_q[2]))
                               : samp_q[0];

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t     state;
    logic       armed;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic       par_bit;
    logic       cfg_bit8;
    logic       cfg_par_en;
    logic       cfg_odd;
    logic [2:0] last_bit;

    // Completion hand-off. The FSM captures the finished frame on the
    // stop-bit tick. The holding register picks it up on the next edge, so
    // the FSM may start a new frame at once without disturbing it.
    logic       done_q;
    logic [7:0] frame_q;
    logic       frame_perr_q;

    assign last_bit = cfg_bit8 ? 3'd7 : 3'd6;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            tick_cnt     <= 4'd0;
            bit_cnt      <= 3'd0;
            shift_q      <= 8'h00;
            par_bit      <= 1'b0;
            cfg_bit8     <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_odd      <= 1'b0;
            done_q       <= 1'b0;
            frame_q      <= 8'h00;
            frame_perr_q <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            framing_err <= 1'b0;
            if (baud_clock) begin
                // The line must be seen high before the next start is
                // accepted. A held-low line (break) therefore gives one
                // frame only.
                if (rx_filt) begin
                    armed <= 1'b1;
                end
                if (state != S_IDLE) begin
                    tick_cnt <= tick_cnt + 4'd1;
                end
                case (state)
                    S_IDLE: begin
                        if (armed && !rx_filt) begin
                            state      <= S_START;
                            armed      <= 1'b0;
                            tick_cnt   <= 4'd0;
                            bit_cnt    <= 3'd0;
                            shift_q    <= 8'h00;
                            par_bit    <= 1'b0;
                            // Config is frozen for the whole frame.
                            cfg_bit8   <= bit8;
                            cfg_par_en <= parity_en;
                            cfg_odd    <= odd_n_even;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == 4'd7) begin
                            if (!rx_filt) begin
                                state    <= S_DATA;
                                tick_cnt <= 4'd0;
                            end else begin
                                // The line went back high by mid-bit, so
                                // this was a false start.
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == 4'd15) begin
                            shift_q[bit_cnt] <= rx_filt;
                            bit_cnt          <= bit_cnt + 3'd1;
                            if (bit_cnt == last_bit) begin
                                state <= cfg_par_en ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick_cnt == 4'd15) begin
                            par_bit <= rx_filt;
                            state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt == 4'd15) begin
                            framing_err  <= ~rx_filt;
                            done_q       <= 1'b1;
                            frame_q      <= shift_q;
                            // In 7-bit mode shift_q[7] is still 0, so the
                            // XOR covers exactly the received data bits.
                            frame_perr_q <= cfg_par_en & (^shift_q ^ par_bit ^ cfg_odd);
                            state        <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_byte      <= 8'h00;
            receive_full <= 1'b0;
            parity_err   <= 1'b0;
            overflow     <= 1'b0;
        end else if (done_q) begin
            if (!receive_full || read_rx_byte) begin
                // A read in the completion cycle frees the slot for the
                // new byte. It also retires any earlier overflow.
                rx_byte      <= frame_q;
                receive_full <= 1'b1;
                parity_err   <= frame_perr_q;
                overflow     <= 1'b0;
            end else begin
                overflow <= 1'b1;
            end
        end else if (read_rx_byte && receive_full) begin
            receive_full <= 1'b0;
            parity_err   <= 1'b0;
            overflow     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 CLKs

    logic       CLK = 1'b0;
    logic       RESET;
    logic       baud_clock;
    logic       RX;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic [7:0] rx_byte;
    logic       receive_full;
    logic       parity_err;
    logic       overflow;
    logic       framing_err;

    uart_rx_core #(.SYNC_STAGES(2), .FILTER_EN(1'b1)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .baud_clock   (baud_clock),
        .RX           (RX),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_byte      (rx_byte),
        .receive_full (receive_full),
        .parity_err   (parity_err),
        .overflow     (overflow),
        .framing_err  (framing_err)
    );

    always #5 CLK = ~CLK;

    // Edge history, sampled with the DUT on the rising edge.
    int         cyc       = 0;
    logic [1:0] tick_hist = 2'b00;
    logic       rd_hist   = 1'b0;

    always @(posedge CLK) begin
        cyc       <= cyc + 1;
        tick_hist <= {tick_hist[0], baud_clock};
        rd_hist   <= read_rx_byte;
    end

    initial begin
        baud_clock = 1'b0;
        forever begin
            @(negedge CLK);
            baud_clock = (cyc % 4 == 0);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       full;
        logic       ovf;
        logic       ferr;
        int         start;
        int         stop_idx;
    } exp_t;

    exp_t       sb[$];
    int         total    = 0;
    int         bad      = 0;
    int         fe_seen  = 0;
    int         fe_exp   = 0;
    int         last_evt = 0;
    logic       m_full   = 1'b0;
    logic       m_ovf    = 1'b0;
    logic       m_perr   = 1'b0;
    logic [7:0] m_byte   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Abstract frame model: what the holding register must show once the frame ends.
    task automatic issue(input logic [7:0] data, input int nbits, input logic pen,
                         input logic odd, input logic pbit, input logic stop,
                         input bit read_same);
        logic [7:0] d;
        logic       pe;
        exp_t       e;
        bit8       = (nbits == 8);
        parity_en  = pen;
        odd_n_even = odd;
        d = data;
        if (nbits == 7) d[7] = 1'b0;
        pe = pen & (^d ^ pbit ^ odd);
        if (!stop) fe_exp++;
        if (!m_full || read_same) begin
            m_byte = d;
            m_perr = pe;
            m_full = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
        e.data     = m_byte;
        e.perr     = m_perr;
        e.full     = m_full;
        e.ovf      = m_ovf;
        e.ferr     = ~stop;
        e.start    = cyc;
        e.stop_idx = 1 + nbits + (pen ? 1 : 0);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic rf_d;
        logic ovf_d;
        logic fe_d;
        int   d;
        rf_d  = 1'b0;
        ovf_d = 1'b0;
        fe_d  = 1'b0;
        forever begin
            @(negedge CLK);
            if (framing_err === 1'b1) fe_seen++;
            if ((receive_full === 1'b1 && (rf_d == 1'b0 || rd_hist == 1'b1)) ||
                (overflow === 1'b1 && ovf_d == 1'b0)) begin
                last_evt = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: rx_byte=%02h full=%0b ovf=%0b, required no output",
                             rx_byte, receive_full, overflow);
                end else begin
                    e = sb.pop_front();
                    d = cyc - e.start;
                    check("rx_byte", rx_byte, e.data);
                    check("parity_err", parity_err, e.perr);
                    check("receive_full", receive_full, e.full);
                    check("overflow", overflow, e.ovf);
                    check("framing_err", fe_d, e.ferr);
                    check("latency_after_tick", tick_hist, 2'b10);
                    check("in_stop_bit", (d >= e.stop_idx * BIT_CLKS) && (d < (e.stop_idx + 1) * BIT_CLKS), 1);
                end
            end
            rf_d  = receive_full;
            ovf_d = overflow;
            fe_d  = framing_err;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic align();
        while (cyc % 4 != 0) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits, input logic pen,
                             input logic pbit, input logic stop, input bit scramble);
        RX = 1'b0;
        repeat (BIT_CLKS) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            RX = data[i];
            // Config wiggles mid-frame must not affect the frame in flight.
            if (scramble && i == 1) begin
                bit8       = 1'($urandom);
                parity_en  = 1'($urandom);
                odd_n_even = 1'($urandom);
            end
            repeat (BIT_CLKS) @(negedge CLK);
        end
        if (pen) begin
            RX = pbit;
            repeat (BIT_CLKS) @(negedge CLK);
        end
        RX = stop;
        repeat (BIT_CLKS) @(negedge CLK);
        RX = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic odd, input logic pbit, input logic stop,
                              input bit scramble);
        issue(data, nbits, pen, odd, pbit, stop, 1'b0);
        send_bits(data, nbits, pen, pbit, stop, scramble);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic host_read();
        read_rx_byte = 1'b1;
        @(negedge CLK);
        read_rx_byte = 1'b0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        check("read_full", receive_full, 0);
        check("read_perr", parity_err, 0);
        check("read_ovf", overflow, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_byte"}, rx_byte, 0);
        check({tag, "_full"}, receive_full, 0);
        check({tag, "_perr"}, parity_err, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_ferr"}, framing_err, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int st;
        int lat;
        RESET        = 1'b1;
        RX           = 1'b1;
        bit8         = 1'b1;
        parity_en    = 1'b0;
        odd_n_even   = 1'b0;
        read_rx_byte = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RESET = 1'b0;
        idle(200);

        // 8N1 0xA5; remember the completion offset for the same-cycle read later
        align();
        st = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain();
        lat = last_evt - st;
        idle(128);
        host_read();

        // Even parity: good, then bad, with a read between
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128); host_read();
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(); idle(128); host_read();

        // 7-bit odd parity
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(); idle(128); host_read();

        // False start: 3 ticks low
        RX = 1'b0;
        repeat (12) @(negedge CLK);
        idle(300);
        check("false_start_full", receive_full, 0);

        // One-tick glitch followed closely by a real frame
        align();
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        idle(16);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128); host_read();

        // Overrun: 0x11 unread, then 0x22 dropped
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128);

        // 0x22 again, read pulsed in the completion cycle
        align();
        st = cyc;
        issue(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        fork
            send_bits(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                while (cyc < st + lat - 1) @(negedge CLK);
                read_rx_byte = 1'b1;
                @(negedge CLK);
                read_rx_byte = 1'b0;
            end
        join
        wait_drain(); idle(128);
        host_read();

        // Break: line low for 20 bit times
        issue(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        RX = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge CLK);
        idle(300);
        wait_drain();
        check("break_fe_count", fe_seen, fe_exp);
        host_read();
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128);

        // Reset in the middle of DATA, holding 0xC3
        RX = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_zero("midreset");
        RESET  = 1'b0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_byte = 8'h00;
        idle(300);
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain(); idle(128); host_read();

        // Randomised frames
        for (int k = 0; k < 30; k++) begin
            logic [7:0] data;
            int         nb;
            logic       pen;
            logic       odd;
            logic       pbit;
            logic       stop;
            data = 8'($urandom);
            nb   = ($urandom % 2 == 0) ? 7 : 8;
            pen  = 1'($urandom);
            odd  = 1'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom % 8 != 0);
            if (m_ovf || ($urandom % 2 == 0)) host_read();
            idle($urandom_range(60, 200));
            send_frame(data, nb, pen, odd, pbit, stop, 1'b1);
            wait_drain();
        end

        idle(200);
        check("fe_total", fe_seen, fe_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        bad++;
        $display("FAIL watchdog: run still going at %0t, required completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
